// File: rtl/data_bus_bridge.sv
// Data-side bus bridge for the single-cycle RV32I core: splits the 10-bit byte address between
// data RAM and a peripheral page hosting an LED register, synchronised switches and a prescaled timer.
module data_bus_bridge #(
    parameter int unsigned PRESCALE = 50,
    parameter int unsigned N_LED    = 10,
    parameter int unsigned N_SW     = 10
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [9:0]       daddr,
    input  logic [31:0]      ddata_w,
    input  logic             d_rw,
    output logic [31:0]      ddata_r,
    output logic [7:0]       ram_addr,
    output logic [31:0]      ram_wdata,
    output logic             ram_we,
    input  logic [31:0]      ram_rdata,
    input  logic [N_SW-1:0]  sw_in,
    output logic [N_LED-1:0] led_out,
    output logic             timer_irq
);

    localparam int unsigned      PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    localparam logic [5:0] OFF_LED  = 6'h00;
    localparam logic [5:0] OFF_SW   = 6'h01;
    localparam logic [5:0] OFF_CNT  = 6'h02;
    localparam logic [5:0] OFF_CMP  = 6'h03;
    localparam logic [5:0] OFF_CTRL = 6'h04;

    logic             sel_per_s;
    logic [5:0]       offset_s;
    logic             wr_led_s;
    logic             wr_cnt_s;
    logic             wr_cmp_s;
    logic             wr_ctrl_s;
    logic             tick_s;
    logic             match_hit_s;
    logic [31:0]      per_rdata_s;
    logic             unused_s;

    logic [N_LED-1:0] led_q, led_d;
    logic [N_SW-1:0]  sw_meta_q;
    logic [N_SW-1:0]  sw_sync_q;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      cmp_q, cmp_d;
    logic             en_q, en_d;
    logic             arl_q, arl_d;
    logic             match_q, match_d;
    logic             irq_en_q, irq_en_d;
    logic [PSC_W-1:0] psc_q, psc_d;

    // Address decode and the RAM pass-through path; word access only, so the byte lane bits are dropped.
    assign sel_per_s   = (daddr[9:8] == 2'b11);
    assign offset_s    = daddr[7:2];
    assign ram_addr    = daddr[9:2];
    assign ram_wdata   = ddata_w;
    assign ram_we      = d_rw & ~sel_per_s;
    assign unused_s    = ^daddr[1:0];

    assign wr_led_s    = d_rw & sel_per_s & (offset_s == OFF_LED);
    assign wr_cnt_s    = d_rw & sel_per_s & (offset_s == OFF_CNT);
    assign wr_cmp_s    = d_rw & sel_per_s & (offset_s == OFF_CMP);
    assign wr_ctrl_s   = d_rw & sel_per_s & (offset_s == OFF_CTRL);

    assign tick_s      = en_q & (psc_q == PSC_LAST);
    assign match_hit_s = (cnt_q == cmp_q);

    assign led_out     = led_q;
    assign timer_irq   = match_q & irq_en_q;
    assign ddata_r     = sel_per_s ? per_rdata_s : ram_rdata;

    // Peripheral read mux; the core has no stall path, so this stays purely combinational.
    always_comb begin
        per_rdata_s = 32'd0;
        case (offset_s)
            OFF_LED:  per_rdata_s[N_LED-1:0] = led_q;
            OFF_SW:   per_rdata_s[N_SW-1:0]  = sw_sync_q;
            OFF_CNT:  per_rdata_s            = cnt_q;
            OFF_CMP:  per_rdata_s            = cmp_q;
            OFF_CTRL: per_rdata_s[3:0]       = {irq_en_q, match_q, arl_q, en_q};
            default:  per_rdata_s            = 32'd0;
        endcase
    end

    // Next-state for the LED, compare and control registers written by software.
    always_comb begin
        led_d    = led_q;
        cmp_d    = cmp_q;
        en_d     = en_q;
        arl_d    = arl_q;
        irq_en_d = irq_en_q;
        if (wr_led_s) begin
            led_d = ddata_w[N_LED-1:0];
        end else begin
            led_d = led_q;
        end
        if (wr_cmp_s) begin
            cmp_d = ddata_w;
        end else begin
            cmp_d = cmp_q;
        end
        if (wr_ctrl_s) begin
            en_d     = ddata_w[0];
            arl_d    = ddata_w[1];
            irq_en_d = ddata_w[3];
        end else begin
            en_d     = en_q;
            arl_d    = arl_q;
            irq_en_d = irq_en_q;
        end
    end

    // Timer next-state: a software CNT write beats the tick, and a hardware match beats write-1-to-clear.
    always_comb begin
        cnt_d   = cnt_q;
        match_d = match_q;
        psc_d   = psc_q;
        if (wr_cnt_s) begin
            cnt_d = ddata_w;
        end else if (tick_s && match_hit_s && arl_q) begin
            cnt_d = 32'd0;
        end else if (tick_s) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (tick_s && match_hit_s) begin
            match_d = 1'b1;
        end else if (wr_ctrl_s && ddata_w[2]) begin
            match_d = 1'b0;
        end else begin
            match_d = match_q;
        end
        if (wr_ctrl_s || !en_q || tick_s) begin
            psc_d = {PSC_W{1'b0}};
        end else begin
            psc_d = psc_q + PSC_W'(1);
        end
    end

    // State registers, including the two-flop switch synchroniser.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            led_q     <= {N_LED{1'b0}};
            sw_meta_q <= {N_SW{1'b0}};
            sw_sync_q <= {N_SW{1'b0}};
            cnt_q     <= 32'd0;
            cmp_q     <= 32'hFFFF_FFFF;
            en_q      <= 1'b0;
            arl_q     <= 1'b0;
            match_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            psc_q     <= {PSC_W{1'b0}};
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            en_q      <= en_d;
            arl_q     <= arl_d;
            match_q   <= match_d;
            irq_en_q  <= irq_en_d;
            psc_q     <= psc_d;
        end
    end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Self-checking bench for data_bus_bridge: directed scenarios plus randomized peripheral traffic
// checked against a behavioural model of the register map and timer.
module tb_data_bus_bridge;
    localparam int PRESCALE = 4;
    localparam int N_LED    = 10;
    localparam int N_SW     = 10;
    localparam logic [31:0] LED_MASK = (32'h1 << N_LED) - 32'h1;

    logic             CLK;
    logic             RESET_N;
    logic [9:0]       daddr;
    logic [31:0]      ddata_w;
    logic             d_rw;
    logic [31:0]      ddata_r;
    logic [7:0]       ram_addr;
    logic [31:0]      ram_wdata;
    logic             ram_we;
    logic [31:0]      ram_rdata;
    logic [N_SW-1:0]  sw_in;
    logic [N_LED-1:0] led_out;
    logic             timer_irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram_mem [256];
    logic [31:0] exp_ram [int];
    int          written_q [$];

    logic [31:0]     m_led, m_cnt, m_cmp;
    logic            m_en, m_ar, m_match, m_irqen;
    int              m_phase;
    logic [N_SW-1:0] m_sw_last, m_sw_prev;
    logic            m_tick, m_wr;
    int              m_off;

    data_bus_bridge #(.PRESCALE(PRESCALE), .N_LED(N_LED), .N_SW(N_SW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w), .d_rw(d_rw),
        .ddata_r(ddata_r), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .sw_in(sw_in), .led_out(led_out), .timer_irq(timer_irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Simple synchronous-write, asynchronous-read data RAM behind the bridge
    assign ram_rdata = ram_mem[ram_addr];
    always @(posedge CLK) if (ram_we) ram_mem[ram_addr] <= ram_wdata;

    // Behavioural model of the peripheral page
    assign m_tick = m_en && (m_phase == PRESCALE - 1);
    assign m_wr   = d_rw && (daddr >= 10'h300);
    assign m_off  = (int'(daddr) - 768) / 4;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_led <= 32'd0; m_cnt <= 32'd0; m_cmp <= 32'hFFFF_FFFF;
            m_en <= 1'b0; m_ar <= 1'b0; m_match <= 1'b0; m_irqen <= 1'b0;
            m_phase <= 0; m_sw_last <= '0; m_sw_prev <= '0;
        end else begin
            m_sw_last <= sw_in;
            m_sw_prev <= m_sw_last;
            if (m_wr && m_off == 4 && ddata_w[2]) m_match <= 1'b0;
            if (m_tick && m_cnt == m_cmp) m_match <= 1'b1;
            if (m_tick) m_cnt <= (m_cnt == m_cmp && m_ar) ? 32'd0 : m_cnt + 32'd1;
            if (!m_en || m_tick) m_phase <= 0; else m_phase <= m_phase + 1;
            if (m_wr) begin
                case (m_off)
                    0: m_led <= ddata_w & LED_MASK;
                    2: m_cnt <= ddata_w;
                    3: m_cmp <= ddata_w;
                    4: begin m_en <= ddata_w[0]; m_ar <= ddata_w[1]; m_irqen <= ddata_w[3]; m_phase <= 0; end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [9:0] a);
        int off;
        off = (int'(a) - 768) / 4;
        case (off)
            0: return m_led & LED_MASK;
            1: return 32'(m_sw_prev);
            2: return m_cnt;
            3: return m_cmp;
            4: return {28'd0, m_irqen, m_match, m_ar, m_en};
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_bus(input logic rw, input logic [9:0] a, input logic [31:0] d);
        d_rw = rw; daddr = a; ddata_w = d;
    endtask

    task automatic next_edge();
        @(posedge CLK); #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        set_bus(1'b1, a, d); next_edge();
    endtask

    task automatic test_reset();
        set_bus(1'b0, 10'h308, 32'd0);
        #2 RESET_N = 1'b0;
        #1;
        total++; if (led_out !== 10'd0) begin bad++; $display("FAIL reset_led: got %h want %h", led_out, 10'd0); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %h want 0", ddata_r); end
        daddr = 10'h30C; #1;
        total++; if (ddata_r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_cmp: got %h want ffffffff", ddata_r); end
        daddr = 10'h310; #1;
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", ddata_r); end
        @(posedge CLK); @(posedge CLK); #3 RESET_N = 1'b1;
        next_edge();
    endtask

    task automatic test_ram();
        int word;
        logic rw;
        logic [9:0] a;
        logic [31:0] d;
        set_bus(1'b1, 10'h124, 32'hDEAD_BEEF);
        @(negedge CLK);
        total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL ram_we_wr: got %b want 1", ram_we); end
        total++; if (ram_addr !== 8'h49) begin bad++; $display("FAIL ram_addr: got %h want 49", ram_addr); end
        total++; if (ram_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_wdata: got %h want deadbeef", ram_wdata); end
        exp_ram[32'h49] = 32'hDEAD_BEEF; written_q.push_back(32'h49);
        next_edge();
        set_bus(1'b0, 10'h124, 32'd0);
        @(negedge CLK);
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL ram_we_rd: got %b want 0", ram_we); end
        total++; if (ddata_r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd: got %h want deadbeef", ddata_r); end
        next_edge();
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            if (rw) word = int'($urandom_range(0, 191));
            else word = written_q[$urandom_range(0, written_q.size() - 1)];
            a = 10'(word * 4 + int'($urandom_range(0, 3)));
            d = $urandom;
            set_bus(rw, a, d);
            @(negedge CLK);
            total++; if (ram_we !== rw) begin bad++; $display("FAIL ram_rnd_we: addr %h got %b want %b", a, ram_we, rw); end
            total++; if (ram_addr !== 8'(word)) begin bad++; $display("FAIL ram_rnd_addr: got %h want %h", ram_addr, 8'(word)); end
            if (!rw) begin
                total++; if (ddata_r !== exp_ram[word]) begin bad++; $display("FAIL ram_rnd_rd: addr %h got %h want %h", a, ddata_r, exp_ram[word]); end
            end else begin
                exp_ram[word] = d; written_q.push_back(word);
            end
            next_edge();
        end
    endtask

    task automatic test_led_sw();
        wr(10'h300, 32'hFFFF_FFFF);
        total++; if (led_out !== 10'h3FF) begin bad++; $display("FAIL led_out: got %h want 3ff", led_out); end
        set_bus(1'b0, 10'h300, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'h3FF) begin bad++; $display("FAIL led_rd: got %h want 3ff", ddata_r); end
        next_edge();
        sw_in = 10'h155; set_bus(1'b0, 10'h304, 32'd0);
        @(negedge CLK);
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL sw_0edge: got %h want 0", ddata_r); end
        next_edge(); @(negedge CLK);
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL sw_1edge: got %h want 0", ddata_r); end
        next_edge(); @(negedge CLK);
        total++; if (ddata_r !== 32'h155) begin bad++; $display("FAIL sw_2edge: got %h want 155", ddata_r); end
        next_edge();
        wr(10'h304, 32'd0);
        set_bus(1'b0, 10'h304, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'h155) begin bad++; $display("FAIL sw_ro: got %h want 155", ddata_r); end
        next_edge();
    endtask

    task automatic test_timer();
        int rise;
        rise = -1;
        wr(10'h30C, 32'd3);
        wr(10'h308, 32'd0);
        wr(10'h310, 32'hB);
        set_bus(1'b0, 10'h310, 32'd0);
        for (int n = 1; n <= 40; n++) begin
            next_edge();
            if (timer_irq === 1'b1) begin rise = n; break; end
        end
        total++; if (rise != 16) begin bad++; $display("FAIL timer_rise: got %0d cycles want 16", rise); end
        set_bus(1'b0, 10'h308, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL timer_reload: got %h want 0", ddata_r); end
        next_edge();
        set_bus(1'b0, 10'h310, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'hF) begin bad++; $display("FAIL timer_ctrl: got %h want f", ddata_r); end
        next_edge();
    endtask

    task automatic test_clear_race();
        wr(10'h310, 32'h4);
        wr(10'h308, 32'd0);
        wr(10'h30C, 32'd0);
        wr(10'h310, 32'h9);
        set_bus(1'b0, 10'h310, 32'd0);
        repeat (3) next_edge();
        wr(10'h310, 32'hF);
        set_bus(1'b0, 10'h310, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'hF) begin bad++; $display("FAIL race_match: got %h want f", ddata_r); end
        total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL race_irq: got %b want 1", timer_irq); end
        next_edge();
        wr(10'h310, 32'h4);
        set_bus(1'b0, 10'h310, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL clear_ctrl: got %h want 0", ddata_r); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL clear_irq: got %b want 0", timer_irq); end
        next_edge();
    endtask

    task automatic test_edges();
        wr(10'h310, 32'h4);
        wr(10'h308, 32'hFFFF_FFFF);
        wr(10'h30C, 32'd5);
        wr(10'h310, 32'h1);
        set_bus(1'b0, 10'h308, 32'd0);
        repeat (3) next_edge();
        @(negedge CLK);
        total++; if (ddata_r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre: got %h want ffffffff", ddata_r); end
        next_edge(); @(negedge CLK);
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL wrap_cnt: got %h want 0", ddata_r); end
        next_edge();
        set_bus(1'b0, 10'h310, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'h1) begin bad++; $display("FAIL wrap_nomatch: got %h want 1", ddata_r); end
        next_edge(); next_edge();
        wr(10'h308, 32'h1234);
        set_bus(1'b0, 10'h308, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'h1234) begin bad++; $display("FAIL cnt_wr_wins: got %h want 1234", ddata_r); end
        next_edge();
    endtask

    task automatic test_random();
        logic rw;
        logic [9:0] a;
        logic [31:0] d, exp;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 6))
                0: a = 10'h300;
                1: a = 10'h304;
                2: a = 10'h308;
                3: a = 10'h30C;
                4: a = 10'h310;
                5: a = 10'h3F0;
                default: a = 10'(32'h300 + 4 * $urandom_range(0, 63) + $urandom_range(0, 3));
            endcase
            rw = ($urandom_range(0, 2) == 0);
            if (a[7:2] == 6'h02 || a[7:2] == 6'h03)
                d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8));
            else if (a[7:2] == 6'h04)
                d = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15)) | 32'($urandom_range(0, 3) != 0);
            else
                d = $urandom;
            if ($urandom_range(0, 15) == 0) sw_in = N_SW'($urandom);
            set_bus(rw, a, d);
            @(negedge CLK);
            if (!rw) begin
                exp = model_read(a);
                total++; if (ddata_r !== exp) begin bad++; $display("FAIL rnd_rd: addr %h got %h want %h", a, ddata_r, exp); end
            end
            total++; if (led_out !== m_led[N_LED-1:0]) begin bad++; $display("FAIL rnd_led: got %h want %h", led_out, m_led[N_LED-1:0]); end
            total++; if (timer_irq !== (m_match & m_irqen)) begin bad++; $display("FAIL rnd_irq: got %b want %b", timer_irq, m_match & m_irqen); end
            next_edge();
        end
    endtask

    task automatic test_unmapped();
        wr(10'h310, 32'h4);
        wr(10'h300, 32'h2A5);
        wr(10'h308, 32'h77);
        wr(10'h30C, 32'h99);
        set_bus(1'b0, 10'h3F0, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL unmapped_rd: got %h want 0", ddata_r); end
        next_edge();
        wr(10'h3F0, 32'hFFFF_FFFF);
        wr(10'h3FC, 32'hFFFF_FFFF);
        set_bus(1'b0, 10'h300, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'h2A5) begin bad++; $display("FAIL unmapped_led: got %h want 2a5", ddata_r); end
        daddr = 10'h308; #1;
        total++; if (ddata_r !== 32'h77) begin bad++; $display("FAIL unmapped_cnt: got %h want 77", ddata_r); end
        daddr = 10'h30C; #1;
        total++; if (ddata_r !== 32'h99) begin bad++; $display("FAIL unmapped_cmp: got %h want 99", ddata_r); end
        daddr = 10'h310; #1;
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL unmapped_ctrl: got %h want 0", ddata_r); end
        next_edge();
    endtask

    task automatic test_reset_mid();
        sw_in = 10'h2AA;
        wr(10'h300, 32'h155);
        wr(10'h308, 32'd0);
        wr(10'h30C, 32'd100);
        wr(10'h310, 32'h9);
        set_bus(1'b0, 10'h308, 32'd0);
        repeat (6) next_edge();
        @(negedge CLK);
        total++; if (ddata_r !== 32'd1) begin bad++; $display("FAIL mid_cnt: got %h want 1", ddata_r); end
        #2 RESET_N = 1'b0;
        #1;
        total++; if (led_out !== 10'd0) begin bad++; $display("FAIL rst_led: got %h want 0", led_out); end
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL rst_cnt: got %h want 0", ddata_r); end
        daddr = 10'h30C; #1;
        total++; if (ddata_r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp: got %h want ffffffff", ddata_r); end
        @(posedge CLK); #3 RESET_N = 1'b1;
        set_bus(1'b0, 10'h304, 32'd0); @(negedge CLK);
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL rel_sw0: got %h want 0", ddata_r); end
        next_edge(); @(negedge CLK);
        total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL rel_sw1: got %h want 0", ddata_r); end
        next_edge(); @(negedge CLK);
        total++; if (ddata_r !== 32'h2AA) begin bad++; $display("FAIL rel_sw2: got %h want 2aa", ddata_r); end
        next_edge();
    endtask

    initial begin
        RESET_N = 1'b1;
        d_rw = 1'b0; daddr = 10'd0; ddata_w = 32'd0; sw_in = '0;
        test_reset();
        test_ram();
        test_led_sw();
        test_timer();
        test_clear_race();
        test_edges();
        test_random();
        test_unmapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
